// File: rtl/add_sequencer.sv
// Sequences an N*K-bit addition through one external N-bit ripple adder,
// one slice per SETTLE+1 cycles, least-significant slice first.
module add_sequencer #(
    parameter int unsigned N      = 8,
    parameter int unsigned K      = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*K-1:0]   A,
    input  logic [N*K-1:0]   B,
    input  logic             ci,
    output logic             ready,
    output logic             done,
    output logic [N*K-1:0]   S,
    output logic             co,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    output logic             add_ci,
    input  logic [N-1:0]     add_s,
    input  logic             add_co
);

    localparam int unsigned W  = N * K;
    localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE);
    localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_nxt;
    logic [W-1:0]  b_nxt;

    // Operand copies shift down so the next slice always sits in the low N bits.
    assign a_nxt = a_q >> N;
    assign b_nxt = b_q >> N;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            cnt    <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            S      <= '0;
            co     <= 1'b0;
            add_a  <= '0;
            add_b  <= '0;
            add_ci <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= A;
                        b_q    <= B;
                        idx    <= '0;
                        cnt    <= CNT_INIT;
                        add_a  <= A[N-1:0];
                        add_b  <= B[N-1:0];
                        add_ci <= ci;
                        ready  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        for (int unsigned i = 0; i < K; i++) begin
                            if (idx == IW'(i)) begin
                                S[i*N +: N] <= add_s;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            co    <= add_co;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Carry between slices travels only through the adder's carry pins.
                            idx    <= idx + IW'(1);
                            a_q    <= a_nxt;
                            b_q    <= b_nxt;
                            add_a  <= a_nxt[N-1:0];
                            add_b  <= b_nxt[N-1:0];
                            add_ci <= add_co;
                            cnt    <= CNT_INIT;
                        end
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sequencer.sv
// Bench for add_sequencer: a SETTLE=2 instance for directed/random cases and a
// SETTLE=0 instance for bulk random operands, both against an arithmetic model.
module tb_add_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: SETTLE = 2
    logic        start0, ci0, ready0, done0, co0, add_ci0, add_co0;
    logic [31:0] a0, b0, s0;
    logic [7:0]  add_a0, add_b0, add_s0;
    assign {add_co0, add_s0} = 9'(add_a0) + 9'(add_b0) + 9'(add_ci0);

    // Instance 1: SETTLE = 0
    logic        start1, ci1, ready1, done1, co1, add_ci1, add_co1;
    logic [31:0] a1, b1, s1;
    logic [7:0]  add_a1, add_b1, add_s1;
    assign {add_co1, add_s1} = 9'(add_a1) + 9'(add_b1) + 9'(add_ci1);

    add_sequencer #(.N(8), .K(4), .SETTLE(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .ci(ci0),
        .ready(ready0), .done(done0), .S(s0), .co(co0),
        .add_a(add_a0), .add_b(add_b0), .add_ci(add_ci0),
        .add_s(add_s0), .add_co(add_co0)
    );

    add_sequencer #(.N(8), .K(4), .SETTLE(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .ci(ci1),
        .ready(ready1), .done(done1), .S(s1), .co(co1),
        .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1),
        .add_s(add_s1), .add_co(add_co1)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b, input logic c);
        return 33'(a) + 33'(b) + 33'(c);
    endfunction

    // Carry entering slice s of a byte-sliced addition.
    function automatic logic carry_into(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input int s);
        logic [32:0] m;
        logic [32:0] t;
        if (s == 0) return c;
        m = (33'd1 << (8 * s)) - 33'd1;
        t = (33'(a) & m) + (33'(b) & m) + 33'(c);
        return t[8*s];
    endfunction

    task automatic wait_ready0();
        int n = 0;
        while (ready0 !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("ready0_timeout", 64'(ready0), 64'd1);
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (ready1 !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("ready1_timeout", 64'(ready1), 64'd1);
    endtask

    // Entered just after the accept edge; counts edges until done, checking slice operands.
    task automatic track0(input logic [31:0] a, input logic [31:0] b, input logic c,
                          output int lat, output int bad);
        int s;
        lat = -1;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            if (done0 === 1'b1) begin
                lat = k;
                break;
            end
            if (k < 12) begin
                s = k / 3;
                if (add_a0 !== a[8*s +: 8] || add_b0 !== b[8*s +: 8] ||
                    add_ci0 !== carry_into(a, b, c, s))
                    bad++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic c, input string tag);
        int lat, bad;
        wait_ready0();
        @(negedge clk);
        a0 = a; b0 = b; ci0 = c; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        check({tag, "_ready_low"}, 64'(ready0), 64'd0);
        track0(a, b, c, lat, bad);
        check({tag, "_latency"}, 64'(lat), 64'd12);
        check({tag, "_slice_ops"}, 64'(bad), 64'd0);
        check({tag, "_sum"}, 64'({co0, s0}), 64'(ref_sum(a, b, c)));
        @(posedge clk); #1;
        check({tag, "_done_once"}, 64'(done0), 64'd0);
        check({tag, "_ready_back"}, 64'(ready0), 64'd1);
    endtask

    initial begin
        int lat, bad, dones;
        logic [31:0] x1, y1, x2, y2, ra, rb;
        logic c1, c2, rc;

        rst = 1'b1;
        start0 = 1'b0; a0 = '0; b0 = '0; ci0 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready0), 64'd1);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_sum", 64'({co0, s0}), 64'd0);
        check("rst_add", 64'({add_a0, add_b0, add_ci0}), 64'd0);
        check("rst_ready1", 64'(ready1), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        op0(32'h0000_00FF, 32'h0000_0001, 1'b0, "carry_chain");
        op0(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "ripple_ci");
        op0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "all_ones");
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            op0(ra, rb, rc, "rand_s2");
        end

        // start held high; operands changed mid-run
        x1 = 32'hDEAD_BEEF; y1 = 32'h2152_4111; c1 = 1'b1;
        x2 = 32'h0123_4567; y2 = 32'h89AB_CDEF; c2 = 1'b0;
        wait_ready0();
        @(negedge clk);
        a0 = x1; b0 = y1; ci0 = c1; start0 = 1'b1;
        @(posedge clk); #1;
        a0 = x2; b0 = y2; ci0 = c2;
        track0(x1, y1, c1, lat, bad);
        check("hold_latency", 64'(lat), 64'd12);
        check("hold_slice_ops", 64'(bad), 64'd0);
        check("hold_sum", 64'({co0, s0}), 64'(ref_sum(x1, y1, c1)));
        @(posedge clk); #1;
        check("hold_idle_ready", 64'(ready0), 64'd1);
        check("hold_done_once", 64'(done0), 64'd0);
        @(posedge clk); #1;
        check("hold_second_accept", 64'(ready0), 64'd0);
        start0 = 1'b0;
        track0(x2, y2, c2, lat, bad);
        check("hold2_latency", 64'(lat), 64'd12);
        check("hold2_sum", 64'({co0, s0}), 64'(ref_sum(x2, y2, c2)));

        // reset during slice 2
        wait_ready0();
        @(negedge clk);
        a0 = 32'h1234_5678; b0 = 32'h1111_1111; ci0 = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_low_slices", 64'(s0[15:0]),
              64'(16'(ref_sum(32'h1234_5678, 32'h1111_1111, 1'b0))));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(ready0), 64'd1);
        check("midrst_done", 64'(done0), 64'd0);
        check("midrst_sum", 64'({co0, s0}), 64'd0);
        check("midrst_add", 64'({add_a0, add_b0, add_ci0}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        op0(32'h1234_5678, 32'h1111_1111, 1'b0, "after_rst");
        check("after_rst_value", 64'({co0, s0}), 64'h0_2345_6789);

        // SETTLE=0 instance, bulk random
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            if (i % 50 == 0) ra = 32'hFFFF_FFFF;
            if (i % 50 == 1) rb = ~ra;
            wait_ready1();
            @(negedge clk);
            a1 = ra; b1 = rb; ci1 = rc; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            lat = -1;
            for (int k = 0; k < 50; k++) begin
                if (done1 === 1'b1) begin
                    lat = k;
                    break;
                end
                @(posedge clk); #1;
            end
            check("s0_latency", 64'(lat), 64'd4);
            check("s0_sum", 64'({co1, s1}), 64'(ref_sum(ra, rb, rc)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
